// File: rtl/alu_rx_pkg.sv
// Shared definitions for the ALU receive framer: state encoding,
// byte-index width helper and the default inter-byte timeout.
package alu_rx_pkg;

  typedef enum logic [1:0] {
    COLLECT_A  = 2'd0,
    COLLECT_B  = 2'd1,
    COLLECT_OP = 2'd2,
    READY      = 2'd3
  } rx_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

  // A single-byte operand still needs a 1-bit index register.
  function automatic int byteIdxWidth(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// raises expire on the final allowed cycle. TIMEOUT_CYCLES=0 disables it.
module byte_timeout_timer
  import alu_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT_CYCLES == 0) begin : gen_disabled
    logic unusedInputs;
    assign unusedInputs = ^{i_clk, i_reset, clear, enable};
    assign expire = 1'b0;
  end else begin : gen_timer
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    assign expire = enable && (count_q == LAST);

    // The counter parks at zero whenever no frame is in progress.
    always_comb begin
      count_d = count_q + 1'b1;
      if (clear || !enable || expire) begin
        count_d = '0;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end
  end

endmodule

// File: rtl/alu_frame_rx.sv
// Receive-side framer: assembles little-endian operands A and B plus an
// opcode byte from the UART stream and hands them to the ALU.
module alu_frame_rx
  import alu_rx_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int OPCODE_W       = 6,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [7:0]          i_data,
  input  logic                i_reception_done,
  input  logic                i_alu_result_ready,
  output logic [DATA_W-1:0]   o_data_A,
  output logic [DATA_W-1:0]   o_data_B,
  output logic [OPCODE_W-1:0] o_opcode,
  output logic                o_ready,
  output logic                o_timeout,
  output logic                o_overrun
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = byteIdxWidth(BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  rx_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] shadowA_q, shadowA_d, shadowB_q, shadowB_d;
  logic [DATA_W-1:0] dataA_q, dataA_d, dataB_q, dataB_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic ready_q, ready_d, timeout_q, timeout_d, overrun_q, overrun_d;
  logic byteAccepted, inProgress, expire;

  assign inProgress = (state_q != READY) && !(state_q == COLLECT_A && idx_q == '0);

  byte_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .clear  (byteAccepted),
    .enable (inProgress),
    .expire (expire)
  );

  // A strobe always takes priority over an expiring timer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadowA_d    = shadowA_q;
    shadowB_d    = shadowB_q;
    dataA_d      = dataA_q;
    dataB_d      = dataB_q;
    opcode_d     = opcode_q;
    ready_d      = ready_q;
    timeout_d    = 1'b0;
    overrun_d    = 1'b0;
    byteAccepted = 1'b0;

    case (state_q)
      COLLECT_A, COLLECT_B: begin
        if (i_reception_done) begin
          byteAccepted = 1'b1;
          for (int b = 0; b < BYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
              if (state_q == COLLECT_A) shadowA_d[b*8 +: 8] = i_data;
              else                      shadowB_d[b*8 +: 8] = i_data;
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (state_q == COLLECT_A) ? COLLECT_B : COLLECT_OP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (expire) begin
          state_d   = COLLECT_A;
          idx_d     = '0;
          shadowA_d = '0;
          shadowB_d = '0;
          timeout_d = 1'b1;
        end
      end
      COLLECT_OP: begin
        if (i_reception_done) begin
          byteAccepted = 1'b1;
          dataA_d      = shadowA_q;
          dataB_d      = shadowB_q;
          opcode_d     = i_data[OPCODE_W-1:0];
          ready_d      = 1'b1;
          idx_d        = '0;
          state_d      = READY;
        end else if (expire) begin
          state_d   = COLLECT_A;
          idx_d     = '0;
          shadowA_d = '0;
          shadowB_d = '0;
          timeout_d = 1'b1;
        end
      end
      READY: begin
        overrun_d = i_reception_done;
        if (i_alu_result_ready) begin
          ready_d = 1'b0;
          idx_d   = '0;
          state_d = COLLECT_A;
        end
      end
      default: begin
        state_d = COLLECT_A;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= COLLECT_A;
      idx_q     <= '0;
      shadowA_q <= '0;
      shadowB_q <= '0;
      dataA_q   <= '0;
      dataB_q   <= '0;
      opcode_q  <= '0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadowA_q <= shadowA_d;
      shadowB_q <= shadowB_d;
      dataA_q   <= dataA_d;
      dataB_q   <= dataB_d;
      opcode_q  <= opcode_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data_A  = dataA_q;
  assign o_data_B  = dataB_q;
  assign o_opcode  = opcode_q;
  assign o_ready   = ready_q;
  assign o_timeout = timeout_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_alu_frame_rx.sv
// Directed bench for alu_frame_rx: a 16-bit/timeout-20 instance driven by a
// vector table and hand sequences, plus an 8-bit instance with no timeout.
module tb_alu_frame_rx;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] dataIn;
  logic strobe;
  logic aluRdy;
  logic [15:0] dataA, dataB;
  logic [5:0] opcode;
  logic ready, timeout, overrun;

  logic [7:0] data8;
  logic strobe8;
  logic [7:0] dataA8, dataB8;
  logic [5:0] opcode8;
  logic ready8, timeout8, overrun8;

  int checks = 0;
  int failures = 0;
  int toCount;
  int toStep;

  typedef struct {
    logic [7:0]  data;
    logic        strobe;
    logic        aluRdy;
    logic [15:0] expA;
    logic [15:0] expB;
    logic [5:0]  expOp;
    logic        expReady;
    logic        expOverrun;
  } vec_t;

  vec_t vecs[22];

  always #5 clk = ~clk;

  alu_frame_rx #(.DATA_W(16), .OPCODE_W(6), .TIMEOUT_CYCLES(20)) dut (
    .i_clk(clk), .i_reset(rst), .i_data(dataIn), .i_reception_done(strobe),
    .i_alu_result_ready(aluRdy), .o_data_A(dataA), .o_data_B(dataB),
    .o_opcode(opcode), .o_ready(ready), .o_timeout(timeout), .o_overrun(overrun)
  );

  alu_frame_rx #(.DATA_W(8), .OPCODE_W(6), .TIMEOUT_CYCLES(0)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_data(data8), .i_reception_done(strobe8),
    .i_alu_result_ready(1'b0), .o_data_A(dataA8), .o_data_B(dataB8),
    .o_opcode(opcode8), .o_ready(ready8), .o_timeout(timeout8), .o_overrun(overrun8)
  );

  // Drive one cycle of inputs on the main instance, then sample 1 ns after the edge.
  task automatic applyStimulus(input logic [7:0] d, input logic s, input logic a);
    dataIn = d;
    strobe = s;
    aluRdy = a;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkMain(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [5:0] op, input logic r);
    checkOutput({tag, "_A"}, 32'(dataA), 32'(a));
    checkOutput({tag, "_B"}, 32'(dataB), 32'(b));
    checkOutput({tag, "_op"}, 32'(opcode), 32'(op));
    checkOutput({tag, "_ready"}, 32'(ready), 32'(r));
  endtask

  task automatic sendByte8(input logic [7:0] d);
    data8   = d;
    strobe8 = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    strobe8 = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{8'h34, 1, 0, 16'h0000, 16'h0000, 6'h00, 0, 0};
    vecs[1]  = '{8'h12, 1, 0, 16'h0000, 16'h0000, 6'h00, 0, 0};
    vecs[2]  = '{8'h78, 1, 0, 16'h0000, 16'h0000, 6'h00, 0, 0};
    vecs[3]  = '{8'h56, 1, 0, 16'h0000, 16'h0000, 6'h00, 0, 0};
    vecs[4]  = '{8'hE0, 1, 0, 16'h1234, 16'h5678, 6'h20, 1, 0};
    vecs[5]  = '{8'hFF, 1, 0, 16'h1234, 16'h5678, 6'h20, 1, 1};
    vecs[6]  = '{8'h00, 0, 0, 16'h1234, 16'h5678, 6'h20, 1, 0};
    vecs[7]  = '{8'h00, 0, 1, 16'h1234, 16'h5678, 6'h20, 0, 0};
    vecs[8]  = '{8'h00, 0, 0, 16'h1234, 16'h5678, 6'h20, 0, 0};
    vecs[9]  = '{8'h01, 1, 0, 16'h1234, 16'h5678, 6'h20, 0, 0};
    vecs[10] = '{8'h00, 1, 0, 16'h1234, 16'h5678, 6'h20, 0, 0};
    vecs[11] = '{8'h02, 1, 0, 16'h1234, 16'h5678, 6'h20, 0, 0};
    vecs[12] = '{8'h00, 1, 0, 16'h1234, 16'h5678, 6'h20, 0, 0};
    vecs[13] = '{8'h24, 1, 0, 16'h0001, 16'h0002, 6'h24, 1, 0};
    vecs[14] = '{8'hAA, 1, 1, 16'h0001, 16'h0002, 6'h24, 0, 1};
    vecs[15] = '{8'h11, 1, 0, 16'h0001, 16'h0002, 6'h24, 0, 0};
    vecs[16] = '{8'h22, 1, 0, 16'h0001, 16'h0002, 6'h24, 0, 0};
    vecs[17] = '{8'h33, 1, 0, 16'h0001, 16'h0002, 6'h24, 0, 0};
    vecs[18] = '{8'h44, 1, 0, 16'h0001, 16'h0002, 6'h24, 0, 0};
    vecs[19] = '{8'h05, 1, 0, 16'h2211, 16'h4433, 6'h05, 1, 0};
    vecs[20] = '{8'h00, 0, 1, 16'h2211, 16'h4433, 6'h05, 0, 0};
    vecs[21] = '{8'h00, 0, 0, 16'h2211, 16'h4433, 6'h05, 0, 0};

    data8   = 8'h00;
    strobe8 = 1'b0;
    rst     = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checkMain("reset", 16'h0, 16'h0, 6'h0, 1'b0);
    checkOutput("reset_timeout", 32'(timeout), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    checkOutput("reset8_A", 32'(dataA8), 32'd0);
    checkOutput("reset8_ready", 32'(ready8), 32'd0);

    // Full frames, overrun in READY, overrun coinciding with done.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].data, vecs[i].strobe, vecs[i].aluRdy);
      checkMain($sformatf("vec%0d", i), vecs[i].expA, vecs[i].expB, vecs[i].expOp, vecs[i].expReady);
      checkOutput($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].expOverrun));
      checkOutput($sformatf("vec%0d_timeout", i), 32'(timeout), 32'd0);
    end

    // Partial frame abandoned: exactly one pulse, 20 cycles after last byte.
    applyStimulus(8'h34, 1'b1, 1'b0);
    applyStimulus(8'h12, 1'b1, 1'b0);
    applyStimulus(8'h78, 1'b1, 1'b0);
    toCount = 0;
    toStep  = -1;
    for (int i = 1; i <= 25; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0);
      if (timeout === 1'b1) begin
        toCount++;
        toStep = i;
      end
    end
    checkOutput("timeout_count", 32'(toCount), 32'd1);
    checkOutput("timeout_step", 32'(toStep), 32'd20);
    checkMain("timeout_hold", 16'h2211, 16'h4433, 6'h05, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'h24, 1'b1, 1'b0);
    checkMain("after_timeout", 16'h0001, 16'h0002, 6'h24, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("after_timeout_done", 32'(ready), 32'd0);

    // Byte landing on the expiry cycle is accepted.
    applyStimulus(8'h34, 1'b1, 1'b0);
    applyStimulus(8'h12, 1'b1, 1'b0);
    toCount = 0;
    for (int i = 1; i <= 19; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0);
      if (timeout === 1'b1) toCount++;
    end
    applyStimulus(8'h78, 1'b1, 1'b0);
    if (timeout === 1'b1) toCount++;
    applyStimulus(8'h56, 1'b1, 1'b0);
    applyStimulus(8'hE0, 1'b1, 1'b0);
    checkOutput("edge_no_timeout", 32'(toCount), 32'd0);
    checkMain("edge_frame", 16'h1234, 16'h5678, 6'h20, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1);

    toCount = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0);
      if (timeout === 1'b1) toCount++;
    end
    checkOutput("idle_no_timeout", 32'(toCount), 32'd0);

    // Reset mid-frame, then a clean frame.
    applyStimulus(8'h34, 1'b1, 1'b0);
    applyStimulus(8'h12, 1'b1, 1'b0);
    applyStimulus(8'h78, 1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checkMain("midreset", 16'h0, 16'h0, 6'h0, 1'b0);
    checkOutput("midreset_timeout", 32'(timeout), 32'd0);
    checkOutput("midreset_overrun", 32'(overrun), 32'd0);
    applyStimulus(8'hAB, 1'b1, 1'b0);
    applyStimulus(8'hCD, 1'b1, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'hEF, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    checkMain("post_reset", 16'hCDAB, 16'hEF01, 6'h3F, 1'b1);

    // 8-bit instance, timeout disabled, long mid-frame gap.
    sendByte8(8'h05);
    sendByte8(8'h03);
    toCount = 0;
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0);
      if (timeout8 === 1'b1) toCount++;
    end
    checkOutput("w8_gap_ready", 32'(ready8), 32'd0);
    sendByte8(8'h20);
    checkOutput("w8_no_timeout", 32'(toCount), 32'd0);
    checkOutput("w8_A", 32'(dataA8), 32'h05);
    checkOutput("w8_B", 32'(dataB8), 32'h03);
    checkOutput("w8_op", 32'(opcode8), 32'h20);
    checkOutput("w8_ready", 32'(ready8), 32'd1);
    checkOutput("w8_overrun", 32'(overrun8), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_frame_rx.md
# alu_frame_rx

Parametrised receive-side framer between the UART receiver and the ALU. Assembles multi-byte operands A and B and an opcode from a stream of received bytes, then presents them to the ALU with a ready/done handshake. Adds what the 8-bit single-byte interface lacks:
- configurable operand width;
- an inter-byte timeout that resynchronises a broken frame;
- overrun reporting for bytes arriving while the ALU is busy.

## Interface
- DATA_W, 8, operand width in bits; multiple of 8, range 8..32; BYTES = DATA_W/8 bytes per operand
- OPCODE_W, 6, opcode width; taken from the LSBs of the single opcode byte; range 1..8
- TIMEOUT_CYCLES, 100000, max i_clk cycles allowed between bytes of one frame; 0 disables the timeout
- i_clk  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_data  in  8  received byte, valid when i_reception_done=1
- i_reception_done  in  1  one-cycle strobe per received byte
- i_alu_result_ready  in  1  ALU finished the current operation; sampled only in READY
- o_data_A  out  DATA_W  committed operand A
- o_data_B  out  DATA_W  committed operand B
- o_opcode  out  OPCODE_W  committed opcode
- o_ready  out  1  committed operands valid, ALU may operate
- o_timeout  out  1  one-cycle pulse: partial frame discarded by timeout
- o_overrun  out  1  one-cycle pulse: byte received in READY and dropped

## Operation
- Frame: BYTES bytes of A, BYTES bytes of B, 1 opcode byte; multi-byte operands little-endian (first byte = bits 7:0).
- FSM states:
  - COLLECT_A (reset state)
  - COLLECT_B
  - COLLECT_OP
  - READY
- Byte index counter: width clog2(BYTES) (min 1); cleared on every state change.
- COLLECT_A / COLLECT_B:
  - Each strobe writes i_data into byte [idx] of the shadow register for A or B, then increments idx.
  - On byte BYTES-1: go to the next state.
- COLLECT_OP:
  - Strobe: shadow A/B plus i_data[OPCODE_W-1:0] are copied into the output registers in the same edge.
  - o_ready<=1; go to READY.
- Output registers change only on this commit, so o_data_A/B and o_opcode hold the previous frame during collection.
- READY:
  - i_alu_result_ready=1: o_ready<=0, go to COLLECT_A.
  - Any strobe: byte dropped, o_overrun pulses.
  - Strobe and done in the same cycle: done wins, byte dropped, o_overrun pulses.
- Timeout:
  - Timer clears on every accepted byte.
  - Timer runs only while a frame is in progress (any collect state other than COLLECT_A with idx=0).
  - When the timer reaches TIMEOUT_CYCLES-1 with no strobe: go to COLLECT_A, idx=0, shadow registers cleared, o_timeout pulses.
  - Strobe on the expiry cycle: byte accepted, no timeout.
- Reset, including mid-frame or in READY:
  - state=COLLECT_A, idx=0, timer=0.
  - Shadow and output registers=0.
  - o_ready=o_timeout=o_overrun=0.

## Timing
- All outputs registered; reset value of every output is 0.
- Latency: o_ready and the new output values appear the cycle after the opcode strobe.
- o_ready falls the cycle after i_alu_result_ready is sampled high in READY.
- First byte of the next frame is accepted from the cycle o_ready is low.
- o_timeout asserts exactly TIMEOUT_CYCLES cycles after the last accepted byte; lasts 1 cycle.
- o_overrun asserts the cycle after the offending strobe; lasts 1 cycle.
- Throughput: one byte per cycle accepted if strobes arrive back to back.

## Structure
- Shared package alu_rx_pkg:
  - state encoding constants (2 bits);
  - function for the byte-index width;
  - default TIMEOUT_CYCLES.
- One sub-module: byte_timeout_timer.
  - Parameter TIMEOUT_CYCLES.
  - Inputs: i_clk, i_reset, clear, enable.
  - Output: expire pulse.
  - TIMEOUT_CYCLES=0 ties expire low.
- FSM, shadow registers and output registers in alu_frame_rx.

## Test plan
Unless stated, DATA_W=16, OPCODE_W=6, TIMEOUT_CYCLES=20.
- Full frame: bytes 0x34,0x12,0x78,0x56,0xE0 -> next cycle o_data_A=0x1234, o_data_B=0x5678, o_opcode=0x20, o_ready=1. Then i_alu_result_ready=1 -> o_ready=0 next cycle.
- Timeout: send 0x34,0x12,0x78, then idle 20 cycles -> o_timeout pulses once, outputs unchanged. Then a full frame 0x01,0x00,0x02,0x00,0x24 -> A=0x0001, B=0x0002, opcode=0x24.
- Boundary: a byte arriving exactly on the expiry cycle is accepted with no o_timeout. Idle in COLLECT_A with idx=0 for 1000 cycles -> no o_timeout.
- Overrun: in READY, strobe 0xFF -> o_overrun pulses, outputs unchanged. Strobe together with i_alu_result_ready -> o_ready falls and o_overrun pulses.
- Reset: i_reset after the 3rd byte of a frame, then a full frame -> decoded correctly. All outputs 0 the cycle after reset.
- DATA_W=8, TIMEOUT_CYCLES=0: bytes 0x05,0x03,0x20 -> A=0x05, B=0x03, opcode=0x20. A 10000-cycle gap mid-frame does not abort.
